// File: rtl/bus_arbiter.sv
// Arbitrates a shared DATA_W bus among NUM_REQ requesters with a registered one-hot grant,
// a hold timeout so no requester starves, and a one-cycle dead turnaround between owners.
module bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        in_req,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        out_grant,
  output logic [OW-1:0]             out_owner,
  output logic [DATA_W-1:0]         out_bus,
  output logic                      out_bus_en,
  output logic                      out_timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be at least 1");
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               win_vld;
  logic [OW-1:0]      win_idx;
  int                 cand;
  logic [CW-1:0]      cnt_inc;
  logic               owner_req;
  logic               others_req;
  logic [DATA_W-1:0]  bus_mux;

  // Round-robin search begins at ptr_q, which always points one past the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = FIXED_PRIO ? i : (int'(ptr_q) + i) % NUM_REQ;
      if (!win_vld && in_req[OW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = OW'(cand);
      end
    end
  end

  assign owner_req  = |(in_req & grant_q);
  assign others_req = |(in_req & ~grant_q);
  assign cnt_inc    = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d = OWN;
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      OWN: begin
        cnt_d = cnt_inc;
        // A voluntary release wins over a simultaneous timeout: no pulse in that case.
        if (!owner_req) begin
          state_d = TURN;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_inc == MAX_C && others_req) begin
          state_d   = TURN;
          grant_d   = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) bus_mux = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_grant   = grant_q;
  assign out_owner   = owner_q;
  assign out_bus     = bus_mux;
  assign out_bus_en  = |grant_q;
  assign out_timeout = timeout_q;

endmodule
